// File: rtl/coriolis_pkg.sv
// Shared definitions for the coriolis kernel output-stream blocks: default stream width,
// output-stream FSM state type and a counter-width helper.
package coriolis_pkg;

   // Width of one yn stream word unless a block overrides it.
   localparam int unsigned STREAMW_DEF = 34;

   // Output-stream controller states; encoding fixed here so every user agrees on it.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } ostrm_state_e;

   // Bits needed to hold values 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/coriolis_sync_fifo.sv
// Single-clock FIFO with registered occupancy. Push into an empty FIFO is visible on
// rdata the following cycle. Push when full and pop when empty are dropped, so data is
// never overwritten. rdata reads as zero whenever the FIFO is empty.
module coriolis_sync_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNTW-1:0]  occupancy
);

   localparam int unsigned PTRW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]  wr_ptr_q;
   logic [PTRW-1:0]  rd_ptr_q;
   logic [CNTW-1:0]  count_q;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_q == CNTW'(DEPTH));
   assign empty     = (count_q == '0);
   assign occupancy = count_q;
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign rdata     = empty ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTRW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTRW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNTW'(1);
            2'b01:   count_q <= count_q - CNTW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; left unreset because empty masks rdata.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/coriolis_ker1_subker1_ostrm.sv
// Output stream stage for coriolis kernel 1 / subkernel 1. Buffers NELEM yn words per run
// in a FIFO and presents them with their element index toward the memory writer.
// Build option: define CORIOLIS_OSTRM_STALLCNT_EN to add a 16-bit saturating stall_cnt
// output counting cycles where ovalid is high and oready is low.
module coriolis_ker1_subker1_ostrm
   import coriolis_pkg::*;
#(
   parameter int unsigned STREAMW = STREAMW_DEF,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned NELEM   = 1024,
   parameter int unsigned ADDRW   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ivalid_yn_s0,
   input  logic [STREAMW-1:0] yn_s0,
   output logic               iready,
   output logic               ovalid,
   input  logic               oready,
   output logic [STREAMW-1:0] odata,
   output logic [ADDRW-1:0]   oaddr,
`ifdef CORIOLIS_OSTRM_STALLCNT_EN
   output logic [15:0]        stall_cnt,
`endif
   output logic               done
);

   localparam int unsigned INCNTW = cnt_width(NELEM);
   localparam int unsigned CNTW   = $clog2(DEPTH + 1);
   localparam logic [INCNTW-1:0] LAST_IN   = INCNTW'(NELEM - 1);
   localparam logic [ADDRW-1:0]  LAST_ADDR = ADDRW'(NELEM - 1);

   ostrm_state_e      state_q;
   logic [INCNTW-1:0] in_cnt_q;
   logic [ADDRW-1:0]  oaddr_q;
   logic              done_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [CNTW-1:0]   fifo_occ;
   logic              push;
   logic              pop;
   logic              last_pop;
   logic              run_start;

   // Handshakes are suppressed while rst is high so nothing completes in a reset cycle.
   assign iready    = ~rst & (state_q == StRun) & ~fifo_full;
   assign ovalid    = ~rst & ~fifo_empty;
   assign push      = ivalid_yn_s0 & iready;
   assign pop       = ovalid & oready;
   // By the final pop every word has been pushed, so exactly one word remains buffered.
   assign last_pop  = pop & (oaddr_q == LAST_ADDR) & (fifo_occ == CNTW'(1));
   assign run_start = start & ((state_q == StIdle) | (state_q == StDone));
   assign oaddr     = oaddr_q;
   assign done      = done_q;

   coriolis_sync_fifo #(
      .WIDTH (STREAMW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .wdata     (yn_s0),
      .pop       (pop),
      .rdata     (odata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (fifo_occ)
   );

   // Run control FSM with its input count, output address and registered done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         in_cnt_q <= '0;
         oaddr_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         if (push) begin
            in_cnt_q <= in_cnt_q + INCNTW'(1);
         end
         // Hold at the last index so oaddr never wraps within a run.
         if (pop && (oaddr_q != LAST_ADDR)) begin
            oaddr_q <= oaddr_q + ADDRW'(1);
         end
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StRun;
                  in_cnt_q <= '0;
                  oaddr_q  <= '0;
               end
            end
            StRun: begin
               if (push && (in_cnt_q == LAST_IN)) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (last_pop) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               if (start) begin
                  state_q  <= StRun;
                  done_q   <= 1'b0;
                  in_cnt_q <= '0;
                  oaddr_q  <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef CORIOLIS_OSTRM_STALLCNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of back-pressured output cycles, restarted with each accepted run.
   always_ff @(posedge clk) begin
      if (rst || run_start) begin
         stall_cnt_q <= '0;
      end else if (ovalid && !oready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   logic unused_run_start;
   assign unused_run_start = run_start;
`endif

endmodule

// File: tb/tb_coriolis_ker1_subker1_ostrm.sv
// Scoreboard bench: instance A (NELEM=4) covers basic runs, reset and start handling;
// instance B (NELEM=10, DEPTH=8) covers back-pressure and the full-FIFO corner.
module tb_coriolis_ker1_subker1_ostrm;

   localparam int unsigned W  = 34;
   localparam int unsigned AW = 10;

   typedef struct {
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      int            c;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   logic          start_a, iv_a, ir_a, ov_a, or_a, done_a;
   logic [W-1:0]  yn_a, od_a;
   logic [AW-1:0] oa_a;
   logic          start_b, iv_b, ir_b, ov_b, or_b, done_b;
   logic [W-1:0]  yn_b, od_b;
   logic [AW-1:0] oa_b;
`ifdef CORIOLIS_OSTRM_STALLCNT_EN
   logic [15:0]   stall_a, stall_b;
`endif

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   bit   strict_a   = 1'b0;
   int   last_pop_a = 0;
   int   pops_b     = 0;
   int   kb         = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   coriolis_ker1_subker1_ostrm #(
      .STREAMW (W), .DEPTH (8), .NELEM (4), .ADDRW (AW)
   ) dut_a (
      .clk (clk), .rst (rst), .start (start_a), .ivalid_yn_s0 (iv_a), .yn_s0 (yn_a),
      .iready (ir_a), .ovalid (ov_a), .oready (or_a), .odata (od_a), .oaddr (oa_a),
`ifdef CORIOLIS_OSTRM_STALLCNT_EN
      .stall_cnt (stall_a),
`endif
      .done (done_a)
   );

   coriolis_ker1_subker1_ostrm #(
      .STREAMW (W), .DEPTH (8), .NELEM (10), .ADDRW (AW)
   ) dut_b (
      .clk (clk), .rst (rst), .start (start_b), .ivalid_yn_s0 (iv_b), .yn_s0 (yn_b),
      .iready (ir_b), .ovalid (ov_b), .oready (or_b), .odata (od_b), .oaddr (oa_b),
`ifdef CORIOLIS_OSTRM_STALLCNT_EN
      .stall_cnt (stall_b),
`endif
      .done (done_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] vb(input int k);
      return W'(32'h100 + k);
   endfunction

   task automatic push_exp_a(input logic [W-1:0] d, input int k);
      exp_t e;
      e.d = d; e.a = AW'(k); e.c = cyc;
      q_a.push_back(e);
   endtask

   task automatic push_exp_b(input int k);
      exp_t e;
      e.d = vb(k); e.a = AW'(k); e.c = cyc;
      q_b.push_back(e);
   endtask

   // Offer one word to A until accepted (bounded); expected entry goes to the scoreboard.
   task automatic send_a(input logic [W-1:0] d, input int k);
      iv_a = 1'b1;
      yn_a = d;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (ir_a) begin
            push_exp_a(d, k);
            step();
            iv_a = 1'b0;
            return;
         end
         step();
      end
      chk("a_send_timeout", 0, 1);
      iv_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (done_a) begin
            chk(name, 64'(cyc - last_pop_a), 1);
            return;
         end
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   // Scoreboard monitors: compare every output handshake against the queue head.
   always @(negedge clk) begin
      if (ov_a && or_a) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_out", 0, 1);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            chk("a_odata", od_a, e.d);
            chk("a_oaddr", oa_a, e.a);
            if (strict_a) chk("a_latency", 64'(cyc - e.c), 1);
            last_pop_a = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (ov_b && or_b) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_out", 0, 1);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            chk("b_odata", od_b, e.d);
            chk("b_oaddr", oa_b, e.a);
            pops_b++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start_a = 0; iv_a = 0; yn_a = '0; or_a = 0;
      start_b = 0; iv_b = 0; yn_b = '0; or_b = 0;
      step(); step();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_iready_a", ir_a, 0);
      chk("rst_ovalid_a", ov_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_odata_a", od_a, 0);
      chk("rst_oaddr_a", oa_a, 0);
      chk("rst_iready_b", ir_b, 0);
      chk("rst_ovalid_b", ov_b, 0);

      // Basic run: 1..4 back-to-back with oready high, one-cycle latency
      step();
      start_a = 1; step(); start_a = 0;
      or_a = 1; strict_a = 1;
      for (int k = 0; k < 4; k++) send_a(W'(k + 1), k);
      wait_done_a("a_done_after_last_pop");
      strict_a = 0;
      chk("a_done_iready", ir_a, 0);
      chk("a_done_ovalid", ov_a, 0);
      chk("a_final_oaddr", oa_a, 3);
      chk("a_queue_empty", q_a.size(), 0);

      // Start from DONE, then start during DRAIN is ignored
      step();
      start_a = 1; step(); start_a = 0;
      @(negedge clk);
      chk("a_start_clears_done", done_a, 0);
      chk("a_start_runs", ir_a, 1);
      chk("a_start_oaddr", oa_a, 0);
      step();
      or_a = 0;
      for (int k = 0; k < 4; k++) send_a(W'(32'h10 + k), k);
      or_a = 1; step(); or_a = 0;
      start_a = 1; step(); start_a = 0;
      @(negedge clk);
      chk("a_drain_start_done", done_a, 0);
      chk("a_drain_start_iready", ir_a, 0);
      chk("a_drain_start_oaddr", oa_a, 1);
      step();
      or_a = 1;
      wait_done_a("a_done_after_drain");

      // Reset mid-run discards buffered words; next run restarts at address 0
      step();
      start_a = 1; step(); start_a = 0;
      or_a = 0;
      for (int k = 0; k < 3; k++) send_a(W'(32'h20 + k), k);
      rst = 1; step(); rst = 0;
      q_a.delete();
      @(negedge clk);
      chk("a_rst_ovalid", ov_a, 0);
      chk("a_rst_done", done_a, 0);
      chk("a_rst_iready", ir_a, 0);
      chk("a_rst_odata", od_a, 0);
      step();
      start_a = 1; step(); start_a = 0;
      or_a = 1;
      for (int k = 0; k < 4; k++) send_a(W'(32'h30 + k), k);
      wait_done_a("a_done_after_rst_run");

`ifdef CORIOLIS_OSTRM_STALLCNT_EN
      // Stall counter: five back-pressured cycles
      step();
      start_a = 1; step(); start_a = 0;
      or_a = 0;
      send_a(W'(32'h40), 0);
      @(negedge clk);
      chk("a_stall_start", stall_a, 0);
      repeat (5) @(negedge clk);
      chk("a_stall_5", stall_a, 5);
      step();
      or_a = 1;
      step();
      or_a = 0;
`endif

      // Back-pressure on B: 10 words offered with oready low, only 8 accepted
      step();
      start_b = 1; step(); start_b = 0;
      or_b = 0; kb = 0; iv_b = 1; yn_b = vb(0);
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (kb == 8) begin
            chk("b_full_iready", ir_b, 0);
         end else if (ir_b) begin
            push_exp_b(kb);
            kb++;
         end
         step();
         yn_b = vb(kb);
      end
      chk("b_accepted", kb, 8);

      // Full FIFO with ivalid and oready together: pop only, then iready returns
      or_b = 1;
      @(negedge clk);
      chk("b_full_pop_no_push", ir_b, 0);
      chk("b_full_ovalid", ov_b, 1);
      step();
      or_b = 0;
      @(negedge clk);
      chk("b_iready_after_pop", ir_b, 1);
      if (ir_b) begin
         push_exp_b(kb);
         kb++;
      end
      step();
      yn_b = vb(kb);
      or_b = 1;
      for (int c = 0; c < 20 && kb < 10; c++) begin
         @(negedge clk);
         if (ir_b) begin
            push_exp_b(kb);
            kb++;
         end
         step();
         yn_b = vb(kb);
      end
      iv_b = 0;
      for (int t = 0; t < 40 && !done_b; t++) @(negedge clk);
      chk("b_done", done_b, 1);
      chk("b_pops", pops_b, 10);
      chk("b_queue_empty", q_b.size(), 0);
      chk("b_final_oaddr", oa_b, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/coriolis_ker1_subker1_ostrm.md
CORIOLIS_KER1_SUBKER1_OSTRM -- requirements
Module: coriolis_ker1_subker1_ostrm

Interface
REQ-001 SHALL have parameter STREAMW, default 34, width of the yn stream word.
REQ-002 SHALL have parameter DEPTH, default 8, buffer depth in words (power of two, >=2).
REQ-003 SHALL have parameter NELEM, default 1024, number of elements per kernel run.
REQ-004 SHALL have parameter ADDRW, default 10, output address width (2^ADDRW >= NELEM).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a run.
REQ-008 SHALL have port ivalid_yn_s0, input, 1, upstream yn word valid.
REQ-009 SHALL have port yn_s0, input, STREAMW, upstream yn word.
REQ-010 SHALL have port iready, output, 1, block accepts a yn word this cycle.
REQ-011 SHALL have port ovalid, output, 1, odata/oaddr valid toward the memory writer.
REQ-012 SHALL have port oready, input, 1, memory writer accepts this cycle.
REQ-013 SHALL have port odata, output, STREAMW, buffered yn word.
REQ-014 SHALL have port oaddr, output, ADDRW, element index of odata.
REQ-015 SHALL have port done, output, 1, run complete; held until rst or start.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE->RUN SHALL occur on start; DONE->RUN on start clears done, in-count and oaddr.
REQ-018 In RUN, iready SHALL equal (FIFO not full) and depend on no combinational path from oready.
REQ-019 An input handshake (ivalid_yn_s0 & iready) SHALL push yn_s0 and increment the in-count.
REQ-020 The cycle the NELEM-th word is accepted, the FSM SHALL go RUN->DRAIN; iready SHALL be 0 in IDLE, DRAIN, DONE.
REQ-021 DRAIN->DONE SHALL occur the cycle after the NELEM-th output handshake; done=1 in DONE.
REQ-022 A word pushed into an empty FIFO in cycle N SHALL appear on odata with ovalid=1 in cycle N+1 (latency 1).
REQ-023 ovalid SHALL equal (FIFO not empty); odata SHALL be the head word, stable while ovalid & !oready.
REQ-024 An output handshake (ovalid & oready) SHALL pop the head and increment oaddr by 1.
REQ-025 oaddr SHALL start at 0 each run and reach NELEM-1 on the last word; no wrap within a run.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged, including at DEPTH-1 and when 1.
REQ-027 When full, iready SHALL be 0 even if oready=1 that cycle; a push SHALL never overwrite.
REQ-028 start in RUN or DRAIN SHALL be ignored.
REQ-029 Data order SHALL be preserved: output k equals the k-th accepted input.

Reset
REQ-030 rst SHALL force IDLE, empty FIFO, in-count 0, oaddr 0, iready 0, ovalid 0, done 0 on the next edge.
REQ-031 rst mid-run SHALL discard buffered words; no handshake SHALL complete in the cycle rst is high.
REQ-032 odata SHALL be 0 after reset until the first push.

Configuration
REQ-033 Macro CORIOLIS_OSTRM_STALLCNT_EN, when defined, SHALL add output stall_cnt (16 bits, saturating) counting cycles with ovalid & !oready, cleared by rst and start.
REQ-034 Without CORIOLIS_OSTRM_STALLCNT_EN the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-035 STREAMW default, FSM state typedef and encoding SHALL live in shared package coriolis_pkg.
REQ-036 Buffering SHALL be a sub-module coriolis_sync_fifo (DEPTH, width, full/empty/occupancy); FSM and counters in the top.

Verification
REQ-037 Reset then start, NELEM=4, words 1,2,3,4 back-to-back, oready=1 -> oaddr 0..3 with odata 1..4, each one cycle after its push; done=1 the cycle after the last pop.
REQ-038 oready=0, DEPTH=8, 10 valid words offered -> 8 accepted, iready=0 from the cycle after the 8th push; raising oready -> all 10 output in order.
REQ-039 Full FIFO, ivalid=1 and oready=1 same cycle -> pop only, no push; next cycle iready=1.
REQ-040 rst asserted after 3 of 4 words accepted -> ovalid=0, done=0, IDLE; a new start and 4 words -> oaddr restarts at 0.
REQ-041 start pulsed in DRAIN -> ignored, oaddr continues, done asserts normally; start in DONE -> done cleared, new run.
REQ-042 With CORIOLIS_OSTRM_STALLCNT_EN, oready held 0 for 5 cycles with ovalid=1 -> stall_cnt=5.
